// File: rtl/prbs31_pkg.sv
// Shared constants and types for the PRBS31 (x^31 + x^28 + 1) checker.
package prbs31_pkg;

    localparam int PRBS_LEN   = 31;
    localparam int TAP_A      = 30;
    localparam int TAP_B      = 27;
    localparam int SEED_CNT_W = 5;

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_t;

endpackage

// File: rtl/prbs31_predictor.sv
// 31-bit history register: loads received bits while seeding,
// free-runs on its own feedback once aligned.
module prbs31_predictor
    import prbs31_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic shift_en,
    input  logic load_sel,
    input  logic bit_in,
    output logic p,
    output logic next_zero
);

    logic [PRBS_LEN-1:0] h;

    // Prediction of the next stream bit from the two taps.
    assign p = h[TAP_A] ^ h[TAP_B];

    // High when a load-from-input shift would leave h all-zero (lock-up guard).
    assign next_zero = ~|{h[PRBS_LEN-2:0], bit_in};

    // History shift: received bit while seeding, own prediction while checking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h <= '0;
        end else if (shift_en) begin
            h <= {h[PRBS_LEN-2:0], (load_sel ? bit_in : p)};
        end
    end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive-side checker: self-seeds, compares bit-by-bit, counts
// errors and drops lock when errors in a sliding window reach a threshold.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WIN_LEN    = 64,
    parameter int ERR_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int WIN_W  = $clog2(WIN_LEN);
    localparam int WERR_W = $clog2(WIN_LEN + 1);

    state_t                  state, state_next;
    logic [SEED_CNT_W-1:0]   seed_cnt;
    logic [WIN_W-1:0]        win_cnt;
    logic [WERR_W-1:0]       win_err, win_err_inc;
    logic                    acc, p, next_zero;
    logic                    err, seed_last, win_last, lose, enter_check;

    assign acc = ena & bit_valid;

    prbs31_predictor u_predictor (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (acc),
        .load_sel  (state == SEED),
        .bit_in    (bit_in),
        .p         (p),
        .next_zero (next_zero)
    );

    // Next-state and per-bit decisions; threshold is tested before window restart.
    always_comb begin
        state_next  = state;
        err         = 1'b0;
        seed_last   = 1'b0;
        lose        = 1'b0;
        enter_check = 1'b0;
        win_err_inc = win_err + WERR_W'(1);
        win_last    = (win_cnt == WIN_W'(WIN_LEN - 1));
        case (state)
            SEED: begin
                if (acc && seed_cnt == SEED_CNT_W'(PRBS_LEN - 1)) begin
                    seed_last = 1'b1;
                    if (!next_zero) begin
                        enter_check = 1'b1;
                        state_next  = CHECK;
                    end
                end
            end
            CHECK: begin
                err  = acc & (bit_in ^ p);
                lose = err && (win_err_inc == WERR_W'(ERR_THRESH));
                if (lose) state_next = SEED;
            end
            default: state_next = SEED;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= state_next;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            locked    <= (state_next == CHECK);
            err_pulse <= err;

            if (clr_cnt) begin
                err_count <= '0;
            end else if (err && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end

            if (state == SEED && acc) begin
                seed_cnt <= seed_last ? '0 : seed_cnt + SEED_CNT_W'(1);
            end

            if (enter_check) begin
                win_cnt <= '0;
                win_err <= '0;
            end else if (state == CHECK && acc) begin
                if (win_last) begin
                    win_cnt <= '0;
                    win_err <= '0;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (err) win_err <= win_err_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: default instance plus a small-counter,
// window-threshold instance for saturation and clear behaviour.
module tb_prbs31_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_count_s;

    int          n_pass = 0;
    int          n_checks = 0;
    int          pulses = 0;
    logic [30:0] g;

    always #5 clk = ~clk;

    prbs31_checker #(.CNT_W(16), .WIN_LEN(64), .ERR_THRESH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_valid(bit_valid), .bit_in(bit_in),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    prbs31_checker #(.CNT_W(4), .WIN_LEN(64), .ERR_THRESH(64)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_valid(bit_valid), .bit_in(bit_in),
        .clr_cnt(clr_cnt), .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s)
    );

    task automatic step(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
        if (err_pulse) pulses++;
    endtask

    task automatic gen_bit(output logic b);
        b = g[30] ^ g[27];
        g = {g[29:0], b};
    endtask

    task automatic send_gen(input logic flip);
        logic b;
        gen_bit(b);
        step(1'b1, b ^ flip);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena = 1'b0;
        bit_valid = 1'b1;
        clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena = 1'b1;
        bit_valid = 1'b0;
        pulses = 0;
        g = 31'h7FFFFFFF;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0)
            $display("FAIL reset_default: locked=%b pulse=%b count=%0d want 0/0/0", locked, err_pulse, err_count);
        else n_pass++;
        n_checks++;
        if (locked_s !== 1'b0 || err_count_s !== 4'd0)
            $display("FAIL reset_sat: locked=%b count=%0d want 0/0", locked_s, err_count_s);
        else n_pass++;
    endtask

    task automatic test_lock();
        int early = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            send_gen(1'b0);
            if (locked !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) $display("FAIL lock_early: %0d cycles locked before 31 bits, want 0", early);
        else n_pass++;
        send_gen(1'b0);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL lock_31st: locked=%b want 1", locked);
        else n_pass++;
        for (int i = 0; i < 10000; i++) send_gen(1'b0);
        n_checks++;
        if (pulses != 0 || err_count !== 16'd0 || locked !== 1'b1)
            $display("FAIL lock_clean: pulses=%0d count=%0d locked=%b want 0/0/1", pulses, err_count, locked);
        else n_pass++;
    endtask

    task automatic test_single_error();
        pulses = 0;
        for (int i = 0; i < 99; i++) send_gen(1'b0);
        send_gen(1'b1);
        n_checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1)
            $display("FAIL single_err: pulse=%b count=%0d want 1/1", err_pulse, err_count);
        else n_pass++;
        send_gen(1'b0);
        n_checks++;
        if (err_pulse !== 1'b0 || locked !== 1'b1 || err_count !== 16'd1 || pulses != 1)
            $display("FAIL single_after: pulse=%b locked=%b count=%0d pulses=%0d want 0/1/1/1",
                     err_pulse, locked, err_count, pulses);
        else n_pass++;
    endtask

    task automatic test_loss_relock();
        do_reset();
        for (int i = 0; i < 31; i++) send_gen(1'b0);
        for (int i = 0; i < 16; i++) begin
            send_gen(i % 2 == 1);
            if (i == 13) begin
                n_checks++;
                if (locked !== 1'b1) $display("FAIL loss_7th: locked=%b want 1", locked);
                else n_pass++;
            end
        end
        n_checks++;
        if (locked !== 1'b0 || err_count !== 16'd8 || pulses != 8)
            $display("FAIL loss_8th: locked=%b count=%0d pulses=%0d want 0/8/8", locked, err_count, pulses);
        else n_pass++;
        for (int i = 0; i < 30; i++) send_gen(1'b0);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL relock_early: locked=%b want 0", locked);
        else n_pass++;
        send_gen(1'b0);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL relock: locked=%b want 1", locked);
        else n_pass++;
        for (int i = 0; i < 200; i++) send_gen(1'b0);
        n_checks++;
        if (locked !== 1'b1 || err_count !== 16'd8)
            $display("FAIL relock_clean: locked=%b count=%0d want 1/8", locked, err_count);
        else n_pass++;
    endtask

    task automatic test_two_windows();
        int drops = 0;
        do_reset();
        for (int i = 0; i < 31; i++) send_gen(1'b0);
        for (int i = 0; i < 128; i++) begin
            send_gen(i >= 57 && i <= 70);
            if (locked !== 1'b1) drops++;
        end
        n_checks++;
        if (drops != 0 || err_count !== 16'd14)
            $display("FAIL two_windows: unlocked_cycles=%0d count=%0d want 0/14", drops, err_count);
        else n_pass++;
    endtask

    task automatic test_zero_guard();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0);
            if (locked !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || err_count !== 16'd0)
            $display("FAIL zero_guard: locked_cycles=%0d count=%0d want 0/0", bad, err_count);
        else n_pass++;
    endtask

    task automatic test_gaps_ena();
        int   accepted = 0;
        int   early = 0;
        logic v, b;
        do_reset();
        for (int cyc = 0; cyc < 2000 && accepted < 31; cyc++) begin
            ena = !(cyc >= 20 && cyc < 40);
            v = 1'($urandom_range(0, 1));
            if (ena && v) begin
                gen_bit(b);
                accepted++;
                step(1'b1, b);
            end else begin
                step(v, 1'($urandom_range(0, 1)));
            end
            if (accepted < 31 && locked !== 1'b0) early++;
        end
        n_checks++;
        if (accepted != 31 || locked !== 1'b1 || early != 0)
            $display("FAIL gaps_lock: accepted=%0d locked=%b early=%0d want 31/1/0", accepted, locked, early);
        else n_pass++;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ena = ($urandom_range(0, 9) != 0);
            v = 1'($urandom_range(0, 1));
            if (ena && v) begin
                gen_bit(b);
                step(1'b1, b);
            end else begin
                step(v, 1'($urandom_range(0, 1)));
            end
        end
        ena = 1'b1;
        n_checks++;
        if (pulses != 0 || err_count !== 16'd0 || locked !== 1'b1)
            $display("FAIL gaps_clean: pulses=%0d count=%0d locked=%b want 0/0/1", pulses, err_count, locked);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int         nerr = 0;
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 31; i++) send_gen(1'b0);
        for (int i = 0; i < 80; i++) begin
            send_gen(i % 4 == 3);
            if (i % 4 == 3) begin
                nerr++;
                exp = (nerr > 15) ? 4'd15 : 4'(nerr);
                n_checks++;
                if (err_count_s !== exp || err_pulse_s !== 1'b1)
                    $display("FAIL sat_err%0d: count=%0d pulse=%b want %0d/1", nerr, err_count_s, err_pulse_s, exp);
                else n_pass++;
            end
        end
        n_checks++;
        if (locked_s !== 1'b1) $display("FAIL sat_locked: locked=%b want 1", locked_s);
        else n_pass++;
        clr_cnt = 1'b1;
        send_gen(1'b1);
        clr_cnt = 1'b0;
        n_checks++;
        if (err_count_s !== 4'd0 || err_pulse_s !== 1'b1)
            $display("FAIL clr_vs_err: count=%0d pulse=%b want 0/1", err_count_s, err_pulse_s);
        else n_pass++;
        send_gen(1'b1);
        n_checks++;
        if (err_count_s !== 4'd1) $display("FAIL after_clr: count=%0d want 1", err_count_s);
        else n_pass++;
        rst_n = 1'b0;
        send_gen(1'b1);
        rst_n = 1'b1;
        n_checks++;
        if (locked_s !== 1'b0 || err_count_s !== 4'd0 || err_pulse_s !== 1'b0)
            $display("FAIL mid_reset: locked=%b count=%0d pulse=%b want 0/0/0", locked_s, err_count_s, err_pulse_s);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_two_windows();
        test_zero_guard();
        test_gaps_ena();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
